// File: rtl/key_debounce_array.sv
// Multi-channel push-button debouncer: 2-flop synchronisers, one shared sample
// prescaler and an independent press/hold/release FSM per key channel.

module key_debounce_chan #(
   parameter int STABLE_SAMPLES = 4,
   parameter int LONG_SAMPLES   = 500,
   parameter int REPEAT_SAMPLES = 100
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick_i,
   input  logic s_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic long_o,
   output logic repeat_o
);
   localparam int SC_W = $clog2(STABLE_SAMPLES) + 1;
   localparam int HC_W = $clog2(LONG_SAMPLES) + 1;
   localparam int RC_W = $clog2(REPEAT_SAMPLES) + 1;
   localparam logic [SC_W-1:0] SC_LAST  = SC_W'(STABLE_SAMPLES - 1);
   localparam logic [HC_W-1:0] HC_LONG  = HC_W'(LONG_SAMPLES);
   localparam logic [HC_W-1:0] HC_PRE   = HC_W'(LONG_SAMPLES - 1);
   localparam logic [RC_W-1:0] RC_LAST  = RC_W'(REPEAT_SAMPLES - 1);

   typedef enum logic [1:0] {IDLE, PRESS_PEND, HELD, REL_PEND} state_e;

   state_e          state_q, state_d;
   logic [SC_W-1:0] sc_q, sc_d;
   logic [HC_W-1:0] hc_q, hc_d;
   logic [RC_W-1:0] rc_q, rc_d;
   logic            level_q, level_d, press_q, press_d, rel_q, rel_d;
   logic            long_q, long_d, rep_q, rep_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sc_q    <= '0;
         hc_q    <= '0;
         rc_q    <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         long_q  <= 1'b0;
         rep_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sc_q    <= sc_d;
         hc_q    <= hc_d;
         rc_q    <= rc_d;
         level_q <= level_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         long_q  <= long_d;
         rep_q   <= rep_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sc_d    = sc_q;
      hc_d    = hc_q;
      rc_d    = rc_q;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      long_d  = 1'b0;
      rep_d   = 1'b0;
      if (tick_i) begin
         unique case (state_q)
            IDLE: if (!s_i) begin
               if (STABLE_SAMPLES == 1) begin
                  state_d = HELD;
                  level_d = 1'b1;
                  press_d = 1'b1;
                  hc_d    = '0;
                  rc_d    = '0;
               end else begin
                  state_d = PRESS_PEND;
                  sc_d    = SC_W'(1);
               end
            end
            PRESS_PEND: if (!s_i) begin
               if (sc_q == SC_LAST) begin
                  state_d = HELD;
                  sc_d    = '0;
                  level_d = 1'b1;
                  press_d = 1'b1;
                  hc_d    = '0;
                  rc_d    = '0;
               end else begin
                  sc_d = sc_q + SC_W'(1);
               end
            end else begin
               state_d = IDLE;
               sc_d    = '0;
            end
            HELD: if (!s_i) begin
               if (hc_q != '1) hc_d = hc_q + HC_W'(1);
               if (hc_q == HC_PRE) long_d = 1'b1;
               // rc runs on its own once long has fired, so hc saturation never stops repeats
               if (REPEAT_SAMPLES > 0 && hc_q >= HC_LONG) begin
                  if (rc_q == RC_LAST) begin
                     rep_d = 1'b1;
                     rc_d  = '0;
                  end else begin
                     rc_d = rc_q + RC_W'(1);
                  end
               end
            end else if (STABLE_SAMPLES == 1) begin
               state_d = IDLE;
               level_d = 1'b0;
               rel_d   = 1'b1;
               hc_d    = '0;
               rc_d    = '0;
            end else begin
               state_d = REL_PEND;
               sc_d    = SC_W'(1);
            end
            REL_PEND: if (s_i) begin
               if (sc_q == SC_LAST) begin
                  state_d = IDLE;
                  sc_d    = '0;
                  level_d = 1'b0;
                  rel_d   = 1'b1;
                  hc_d    = '0;
                  rc_d    = '0;
               end else begin
                  sc_d = sc_q + SC_W'(1);
               end
            end else begin
               // glitch rejected: hold timing resumes where it stopped
               state_d = HELD;
               sc_d    = '0;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = rel_q;
   assign long_o    = long_q;
   assign repeat_o  = rep_q;
endmodule

module key_debounce_array #(
   parameter int N_KEYS         = 4,
   parameter int CLK_DIV        = 50000,
   parameter int STABLE_SAMPLES = 4,
   parameter int LONG_SAMPLES   = 500,
   parameter int REPEAT_SAMPLES = 100
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_KEYS-1:0] key_n,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_long,
   output logic [N_KEYS-1:0] key_repeat,
   output logic              sample_tick
);
   localparam int DIV_W = $clog2(CLK_DIV) + 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [N_KEYS-1:0] sync1_q, sync2_q;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              tick, tick_q;

   assign tick  = (div_q == DIV_LAST);
   assign div_d = tick ? '0 : div_q + DIV_W'(1);

   // synchronisers preset to released so reset never looks like a press
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '1;
         sync2_q <= '1;
         div_q   <= '0;
         tick_q  <= 1'b0;
      end else begin
         sync1_q <= key_n;
         sync2_q <= sync1_q;
         div_q   <= div_d;
         tick_q  <= tick;
      end
   end

   assign sample_tick = tick_q;

   for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
      key_debounce_chan #(
         .STABLE_SAMPLES(STABLE_SAMPLES),
         .LONG_SAMPLES  (LONG_SAMPLES),
         .REPEAT_SAMPLES(REPEAT_SAMPLES)
      ) u_chan (
         .clk      (clk),
         .rst_n    (rst_n),
         .tick_i   (tick),
         .s_i      (sync2_q[g]),
         .level_o  (key_level[g]),
         .press_o  (key_press[g]),
         .release_o(key_release[g]),
         .long_o   (key_long[g]),
         .repeat_o (key_repeat[g])
      );
   end
endmodule

// File: tb/tb_key_debounce_array.sv
// Bench for key_debounce_array: tick-aligned scenario table with pulse counts,
// hand-written reset/tick-period sequences, and random key activity vs a model.

module tb_key_debounce_array;
   localparam int N   = 4;
   localparam int DIV = 4;
   localparam int STB = 3;
   localparam int LNG = 10;
   localparam int REP = 5;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [N-1:0] key_n = '1;
   logic [N-1:0] lvl, prs, rel, lng, rpt;
   logic [N-1:0] lvl2, prs2, rel2, lng2, rpt2;
   logic         stk, stk2;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   key_debounce_array #(.N_KEYS(N), .CLK_DIV(DIV), .STABLE_SAMPLES(STB),
                        .LONG_SAMPLES(LNG), .REPEAT_SAMPLES(REP)) dut (
      .clk(clk), .rst_n(rst_n), .key_n(key_n), .key_level(lvl), .key_press(prs),
      .key_release(rel), .key_long(lng), .key_repeat(rpt), .sample_tick(stk));

   key_debounce_array #(.N_KEYS(N), .CLK_DIV(DIV), .STABLE_SAMPLES(STB),
                        .LONG_SAMPLES(LNG), .REPEAT_SAMPLES(0)) dut_norep (
      .clk(clk), .rst_n(rst_n), .key_n(key_n), .key_level(lvl2), .key_press(prs2),
      .key_release(rel2), .key_long(lng2), .key_repeat(rpt2), .sample_tick(stk2));

   // Reference: a key's level flips after STB consecutive disagreeing samples;
   // hold time counts pressed samples taken while the level is already settled.
   int           m_cnt;
   logic [N-1:0] m_s1, m_s2;
   logic [N-1:0] e_lvl, e_prs, e_rel, e_lng, e_rpt;
   logic         e_tick, m_p;
   int           m_run[N];
   int           m_hold[N];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt = 0; m_s1 = '1; m_s2 = '1; e_tick = 1'b0;
         e_lvl = '0; e_prs = '0; e_rel = '0; e_lng = '0; e_rpt = '0;
         for (int i = 0; i < N; i++) begin m_run[i] = 0; m_hold[i] = 0; end
      end else begin
         e_prs = '0; e_rel = '0; e_lng = '0; e_rpt = '0;
         e_tick = (m_cnt == DIV - 1);
         if (e_tick) begin
            for (int i = 0; i < N; i++) begin
               m_p = !m_s2[i];
               if (m_p != e_lvl[i]) begin
                  m_run[i]++;
                  if (m_run[i] >= STB) begin
                     m_run[i] = 0;
                     e_lvl[i] = m_p;
                     m_hold[i] = 0;
                     if (m_p) e_prs[i] = 1'b1; else e_rel[i] = 1'b1;
                  end
               end else if (m_run[i] != 0) begin
                  m_run[i] = 0;
               end else if (m_p) begin
                  m_hold[i]++;
                  if (m_hold[i] == LNG) e_lng[i] = 1'b1;
                  if (m_hold[i] > LNG && (m_hold[i] - LNG) % REP == 0) e_rpt[i] = 1'b1;
               end
            end
         end
         m_s2 = m_s1;
         m_s1 = key_n;
         m_cnt = e_tick ? 0 : m_cnt + 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         n_cmp++;
         if ({lvl, prs, rel, lng, rpt, stk} !== {e_lvl, e_prs, e_rel, e_lng, e_rpt, e_tick}) begin
            n_bad++;
            $display("FAIL cycle_model t=%0t got lvl=%h prs=%h rel=%h lng=%h rpt=%h tick=%b want %h %h %h %h %h %b",
                     $time, lvl, prs, rel, lng, rpt, stk, e_lvl, e_prs, e_rel, e_lng, e_rpt, e_tick);
         end
         n_cmp++;
         if ({lvl2, prs2, rel2, lng2, rpt2, stk2} !== {e_lvl, e_prs, e_rel, e_lng, 4'h0, e_tick}) begin
            n_bad++;
            $display("FAIL cycle_norep t=%0t got lvl=%h prs=%h rel=%h lng=%h rpt=%h tick=%b want %h %h %h %h 0 %b",
                     $time, lvl2, prs2, rel2, lng2, rpt2, stk2, e_lvl, e_prs, e_rel, e_lng, e_tick);
         end
      end
   end

   typedef struct {
      logic [N-1:0] kn;
      int           ticks;
      logic [N-1:0] lv;
      int           np, nr, nl, nrp;
   } row_t;

   row_t rows[$];

   task automatic chk(input string nm, input int idx, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s row %0d: got %0d want %0d", nm, idx, act, exp);
      end
   endtask

   // Starts on the falling edge inside a prescaler count-0 cycle; pulses from
   // the row's last sample land on its final sampled falling edge.
   task automatic run_row(input row_t r, input int idx);
      int np = 0, nr = 0, nl = 0, nrp = 0, nl2 = 0, nrp2 = 0;
      key_n = r.kn;
      repeat (r.ticks * DIV) begin
         @(negedge clk);
         np  += $countones(prs);
         nr  += $countones(rel);
         nl  += $countones(lng);
         nrp += $countones(rpt);
         nl2 += $countones(lng2);
         nrp2 += $countones(rpt2);
      end
      chk("level", idx, int'(lvl), int'(r.lv));
      chk("press_cnt", idx, np, r.np);
      chk("release_cnt", idx, nr, r.nr);
      chk("long_cnt", idx, nl, r.nl);
      chk("repeat_cnt", idx, nrp, r.nrp);
      chk("norep_long_cnt", idx, nl2, r.nl);
      chk("norep_repeat_cnt", idx, nrp2, 0);
   endtask

   initial begin
      int idx, n;
      // clean press of key0, 20-tick hold, release
      rows.push_back(row_t'{4'hF, 2, 4'h0, 0, 0, 0, 0});
      rows.push_back(row_t'{4'hE, 3, 4'h1, 1, 0, 0, 0});
      rows.push_back(row_t'{4'hE, 10, 4'h1, 0, 0, 1, 0});
      rows.push_back(row_t'{4'hE, 10, 4'h1, 0, 0, 0, 2});
      rows.push_back(row_t'{4'hF, 3, 4'h0, 0, 1, 0, 0});
      // key1 bounce: 2 pressed / 1 released, five times
      for (int k = 0; k < 5; k++) begin
         rows.push_back(row_t'{4'hD, 2, 4'h0, 0, 0, 0, 0});
         rows.push_back(row_t'{4'hF, 1, 4'h0, 0, 0, 0, 0});
      end
      rows.push_back(row_t'{4'hF, 2, 4'h0, 0, 0, 0, 0});
      // key2 release glitch at hold 6; long after 10 accumulated hold samples
      rows.push_back(row_t'{4'hB, 3, 4'h4, 1, 0, 0, 0});
      rows.push_back(row_t'{4'hB, 6, 4'h4, 0, 0, 0, 0});
      rows.push_back(row_t'{4'hF, 2, 4'h4, 0, 0, 0, 0});
      rows.push_back(row_t'{4'hB, 4, 4'h4, 0, 0, 0, 0});
      rows.push_back(row_t'{4'hB, 1, 4'h4, 0, 0, 1, 0});
      rows.push_back(row_t'{4'hF, 3, 4'h0, 0, 1, 0, 0});
      // all keys together
      rows.push_back(row_t'{4'h0, 3, 4'hF, 4, 0, 0, 0});
      rows.push_back(row_t'{4'hF, 3, 4'h0, 0, 4, 0, 0});
      // 40-sample hold: repeats at 15..40 on the repeating instance only
      rows.push_back(row_t'{4'hE, 3, 4'h1, 1, 0, 0, 0});
      rows.push_back(row_t'{4'hE, 40, 4'h1, 0, 0, 1, 6});
      rows.push_back(row_t'{4'hF, 3, 4'h0, 0, 1, 0, 0});
      // key3 pressed, held to hold sample 12 before the reset
      rows.push_back(row_t'{4'h7, 3, 4'h8, 1, 0, 0, 0});
      rows.push_back(row_t'{4'h7, 12, 4'h8, 0, 0, 1, 0});

      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      #1 rst_n = 1'b1;
      idx = 0;
      foreach (rows[i]) begin
         run_row(rows[i], idx);
         idx++;
      end

      // reset mid-hold: outputs clear at once, no release pulse
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("async_reset_outs", idx, int'({lvl, prs, rel, lng, rpt, stk}), 0);
      chk("async_reset_norep", idx, int'({lvl2, prs2, rel2, lng2, rpt2, stk2}), 0);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      run_row(row_t'{4'h7, 3, 4'h8, 1, 0, 0, 0}, idx + 1);
      run_row(row_t'{4'hF, 3, 4'h0, 0, 1, 0, 0}, idx + 2);

      // sample_tick spacing
      n = 0;
      do begin @(negedge clk); n++; end while (!stk && n < 20);
      chk("tick_found", idx + 3, int'(stk), 1);
      for (int k = 0; k < 3; k++) begin
         n = 0;
         do begin @(negedge clk); n++; end while (!stk && n < 20);
         chk("tick_period", idx + 4 + k, n, DIV);
      end

      // random key activity with bursts of bounce, checked by the cycle model
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 47) == 0) key_n[b] = ~key_n[b];
      end
      key_n = '1;
      repeat (60) @(negedge clk);
      chk("final_level", idx + 8, int'(lvl), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/key_debounce_array.md
Name: key_debounce_array

Overview:
- Parametrised multi-channel successor to the single-key debouncer. It debounces N_KEYS raw active-low push-buttons on one shared sample tick.
- Per channel it produces a clean pressed level plus single-cycle press, release, long-press and auto-repeat pulses.
- It sits between the board key pins and the recorder control FSM (record/play/stop/volume keys).

Parameters:
- N_KEYS, 4: number of independent key channels.
- CLK_DIV, 50000: clk cycles per sample tick. Must be at least 1; a value of 1 gives a tick every cycle.
- STABLE_SAMPLES, 4: consecutive agreeing samples required to accept a press or a release. Must be at least 1.
- LONG_SAMPLES, 500: held samples after press acceptance before key_long fires. Must be greater than 0.
- REPEAT_SAMPLES, 100: held samples between key_repeat pulses after key_long. A value of 0 disables repeat.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- key_n  in  N_KEYS  raw asynchronous key inputs; 0 means pressed.
- key_level  out  N_KEYS  debounced state; 1 means pressed.
- key_press  out  N_KEYS  one-clk pulse when a press is accepted.
- key_release  out  N_KEYS  one-clk pulse when a release is accepted.
- key_long  out  N_KEYS  one-clk pulse when the hold reaches LONG_SAMPLES.
- key_repeat  out  N_KEYS  one-clk pulse every REPEAT_SAMPLES held samples after key_long.
- sample_tick  out  1  one-clk prescaler tick, exported for other blocks.

Behaviour:
- Reset, asynchronous on rst_n low:
  - all outputs 0;
  - prescaler 0;
  - every channel FSM in IDLE with all counters 0;
  - synchroniser flops preset to 1 (released), so no false press after reset.
- Synchroniser: each key_n bit passes through 2 flops. Call the result s[i] (0 = pressed).
- Prescaler:
  - counts 0..CLK_DIV-1 and wraps;
  - tick is asserted for exactly the cycle in which the count equals CLK_DIV-1;
  - sample_tick is that tick, registered.
- FSM evaluation: channel FSMs advance only on tick cycles. All outputs are registered, so pulses appear in the cycle after the deciding tick and last exactly one clk.
- Per-channel FSM, with stable counter sc and hold counter hc:
  - IDLE: on tick with s=0, go to PRESS_PEND with sc=1. If STABLE_SAMPLES=1, go directly to HELD with the press actions below.
  - PRESS_PEND, on tick with s=0: sc++. When sc reaches STABLE_SAMPLES, go to HELD, set key_level=1, pulse key_press, set hc=0.
  - PRESS_PEND, on tick with s=1: return to IDLE, sc=0. No outputs.
  - HELD, on tick with s=0:
    - hc++, saturating at its maximum;
    - pulse key_long on the tick where hc becomes LONG_SAMPLES;
    - if REPEAT_SAMPLES>0, pulse key_repeat on every tick where hc becomes LONG_SAMPLES + k*REPEAT_SAMPLES, for k ≥ 1.
  - Repeat counter: a separate repeat counter is used, so the repeat cadence is unbounded after hc saturates.
  - HELD, on tick with s=1: go to REL_PEND with sc=1. If STABLE_SAMPLES=1, release immediately.
  - REL_PEND, on tick with s=1: sc++. When sc reaches STABLE_SAMPLES, go to IDLE, set key_level=0, pulse key_release, clear hc and the repeat counter.
  - REL_PEND, on tick with s=0: return to HELD. hc and the repeat counter are frozen across REL_PEND and then resume, so a release glitch does not restart long-press timing.
- key_level holds through PRESS_PEND→HELD and REL_PEND→HELD; it changes only at acceptance.
- Channels are fully independent. Simultaneous events on several channels pulse in the same cycle.
- Counter widths: counters are sized with $clog2 of their parameter plus 1. No overflow wrap is permitted.
- Key held through reset release: the key is treated as a fresh press and reported after STABLE_SAMPLES ticks.
- Reset mid-hold: all state clears immediately. No release pulse is generated.

Test Plan (bench parameters N_KEYS=4, CLK_DIV=4, STABLE_SAMPLES=3, LONG_SAMPLES=10, REPEAT_SAMPLES=5):
- Clean press of key0 held 20 ticks, then released:
  - exactly one key_press[0];
  - key_level[0] rises with it, 3 ticks after s[0] falls (+1 clk);
  - one key_long[0] at hold tick 10;
  - key_repeat[0] at hold ticks 15 and 20;
  - one key_release[0] 3 ticks after release;
  - other channels stay 0.
- Bounce: key1 toggles pressed for 2 ticks, released 1, repeated 5 times, then released → no pulses, key_level[1] stays 0.
- Release glitch: key2 held, released for 2 ticks at hold tick 6, then pressed again → no release pulse; key_long[2] at accumulated hold tick 10, not restarted.
- Simultaneous press on all 4 keys → 4 key_press bits assert in the same cycle, one cycle each.
- rst_n pulled low at hold tick 12 of key3 → all outputs 0 asynchronously; after rst_n high with key still pressed, key_press[3] fires again 3 ticks later.
- REPEAT_SAMPLES=0 variant, hold 40 ticks → single key_long, zero key_repeat; sample_tick period exactly 4 clk throughout.
